seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50_000, CLK_50 cycles per digit slot (1 kHz per digit at 50 MHz); legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 500, cycles at the start of each slot with all digits off (anti-ghosting); legal range 0..SCAN_DIV-2.
REQ-003 Parameter ACT_LOW, default 1, 1 = SEG and DIG active-low (common-anode board), 0 = active-high.
REQ-004 CLK_50  in  1  system clock; one clock domain only.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 BCD  in  16  four BCD digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-007 DP  in  4  decimal-point enable per digit, same indexing as BCD.
REQ-008 LZB  in  1  leading-zero blanking enable.
REQ-009 SEG  out  8  segments; [7] = dp, [6:0] = g..a; polarity per ACT_LOW.
REQ-010 DIG  out  4  one-hot digit enable; polarity per ACT_LOW.
REQ-011 FRAME  out  1  one-cycle pulse when the shadow register loads.

Function
REQ-012 The slot counter SHALL count 0..SCAN_DIV-1 and wrap to 0; the wrap cycle is the slot tick.
REQ-013 On each slot tick, the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-014 BCD and DP SHALL be captured into a shadow register only on the tick where the index wraps 3->0; FRAME SHALL pulse high in that same cycle. Mid-frame input changes SHALL NOT appear until the next frame.
REQ-015 Blanking: DIG SHALL be all-inactive while the slot count < BLANK_CYC; otherwise DIG SHALL assert only bit[index].
REQ-016 SEG SHALL show the decoded shadow digit[index], with dp = shadow DP[index]. SEG and DIG SHALL be registered and change together in the same cycle, with one cycle of latency from the index/count.
REQ-017 Decode: values 0-9 SHALL use the standard 7-segment glyphs; values 10-15 (invalid BCD) SHALL light segment g only ("-").
REQ-018 With LZB=1, digit k (k=3..1) SHALL be blanked (segments and dp off, DIG still scanned) when it and every higher shadow digit equal 0; digit 0 is never blanked. With LZB=0, no digit is blanked.
REQ-019 LZB SHALL be sampled live (not shadowed).
REQ-020 In the ACT_LOW polarity conversion, only the final output stage SHALL invert; all internal logic is active-high.

Reset
REQ-021 While reset_n=0, and asynchronously on its falling edge: slot count=0, index=0, shadow BCD=0, shadow DP=0, FRAME=0, SEG all-off, DIG all-off (polarity applied).
REQ-022 After release, scanning SHALL start at digit 0, and the first shadow load SHALL occur on the first 3->0 wrap. Until then the display shows "0" on digit 0, with digits 3..1 blank if LZB=1.
REQ-023 Reset asserted mid-slot SHALL take effect immediately, with no completion of the current slot.

Structure
REQ-024 Shared package seg_pkg SHALL hold the 7-segment glyph constants (0-9 and dash), the SEG bit-position constants, and the digit count (4).
REQ-025 Decoder sub-module bcd_to_seg7: combinational, 4-bit in / 7-bit active-high out, instantiated once in seg_scan.

Verification
(Use SCAN_DIV=4, BLANK_CYC=1, ACT_LOW=1.)
REQ-026 Reset and release with BCD=16'h1234 -> SEG=8'hFF and DIG=4'hF during reset; after release, DIG cycles 1110,1101,1011,0111 with one all-high cycle per slot; after the first FRAME, digit 0 shows "4" (SEG=8'h99).
REQ-027 BCD changed 16'h1234->16'h5678 mid-frame -> remaining slots of that frame still show 1,2,3; "8" on digit 0 only after the next FRAME pulse.
REQ-028 BCD=16'h0090, LZB=1 -> digits 3 and 2 show SEG=8'hFF; digit 1 "9", digit 0 "0". With LZB=0 -> digits 3 and 2 show "0" (SEG=8'hC0).
REQ-029 BCD=16'h00A0, DP=4'b0001 -> digit 1 SEG=8'hBF (dash); digit 0 SEG=8'h40 ("0" with dp).
REQ-030 reset_n pulsed low for 1 cycle mid-slot on digit 2 -> outputs go off immediately, the index returns to 0, and the shadow is cleared to 0.
REQ-031 Continuous run for 3 frames -> FRAME pulses exactly every 16 cycles, and DIG never has more than one bit active.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: glyphs, segment bit
// positions, digit count and the digit-select helper.
package seg_pkg;

  localparam int NUM_DIG = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high glyphs, bit order g..a.
  localparam logic [6:0] GLYPH_0    = 7'h3F;
  localparam logic [6:0] GLYPH_1    = 7'h06;
  localparam logic [6:0] GLYPH_2    = 7'h5B;
  localparam logic [6:0] GLYPH_3    = 7'h4F;
  localparam logic [6:0] GLYPH_4    = 7'h66;
  localparam logic [6:0] GLYPH_5    = 7'h6D;
  localparam logic [6:0] GLYPH_6    = 7'h7D;
  localparam logic [6:0] GLYPH_7    = 7'h07;
  localparam logic [6:0] GLYPH_8    = 7'h7F;
  localparam logic [6:0] GLYPH_9    = 7'h6F;
  localparam logic [6:0] GLYPH_DASH = 7'h40;

  typedef logic [1:0]         dig_idx_t;
  typedef logic [NUM_DIG-1:0] dig_mask_t;

  function automatic dig_mask_t dig_onehot(input dig_idx_t idx);
    return dig_mask_t'(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Glyph lookup; codes 10..15 fall through to the dash.
  always_comb begin
    seg_o = GLYPH_DASH;
    case (bcd_i)
      4'd0:    seg_o = GLYPH_0;
      4'd1:    seg_o = GLYPH_1;
      4'd2:    seg_o = GLYPH_2;
      4'd3:    seg_o = GLYPH_3;
      4'd4:    seg_o = GLYPH_4;
      4'd5:    seg_o = GLYPH_5;
      4'd6:    seg_o = GLYPH_6;
      4'd7:    seg_o = GLYPH_7;
      4'd8:    seg_o = GLYPH_8;
      4'd9:    seg_o = GLYPH_9;
      default: seg_o = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous shadow
// register, per-slot anti-ghost blanking and leading-zero suppression.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50_000,
  parameter int BLANK_CYC = 500,
  parameter bit ACT_LOW   = 1'b1
) (
  input  logic        CLK_50,
  input  logic        reset_n,
  input  logic [15:0] BCD,
  input  logic [3:0]  DP,
  input  logic        LZB,
  output logic [7:0]  SEG,
  output logic [3:0]  DIG,
  output logic        FRAME
);

  localparam int             CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  dig_idx_t      idx_q, idx_d;
  logic [15:0]   sh_bcd_q, sh_bcd_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic          frame_q, frame_d;
  logic [7:0]    seg_q, seg_d;
  dig_mask_t     dig_q, dig_d;

  logic          tick_s;
  logic          wrap_s;
  logic          in_blank_s;
  logic [3:0]    cur_bcd_s;
  logic [6:0]    glyph_s;
  logic [3:0]    zero_s;
  logic [3:0]    lz_mask_s;

  assign tick_s    = (cnt_q == CNT_MAX);
  assign wrap_s    = tick_s && (idx_q == 2'd3);
  assign cur_bcd_s = sh_bcd_q[{idx_q, 2'b00} +: 4];

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign in_blank_s = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);
      assign in_blank_s = (cnt_q < BLANK_V);
    end
  endgenerate

  bcd_to_seg7 u_dec (
    .bcd_i (cur_bcd_s),
    .seg_o (glyph_s)
  );

  // A digit is suppressed only while it and every digit above it are zero.
  always_comb begin
    for (int k = 0; k < NUM_DIG; k++) begin
      zero_s[k] = (sh_bcd_q[4*k +: 4] == 4'd0);
    end
    lz_mask_s    = 4'b0000;
    lz_mask_s[3] = LZB && zero_s[3];
    lz_mask_s[2] = lz_mask_s[3] && zero_s[2];
    lz_mask_s[1] = lz_mask_s[2] && zero_s[1];
    lz_mask_s[0] = 1'b0;
  end

  // Slot counter, digit index, shadow load and frame pulse next-state.
  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    sh_bcd_d = sh_bcd_q;
    sh_dp_d  = sh_dp_q;
    frame_d  = wrap_s;
    if (tick_s) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (wrap_s) begin
      sh_bcd_d = BCD;
      sh_dp_d  = DP;
    end else begin
      sh_bcd_d = sh_bcd_q;
      sh_dp_d  = sh_dp_q;
    end
  end

  // Active-high segment and digit drive for the current slot.
  always_comb begin
    seg_d = {sh_dp_q[idx_q], glyph_s};
    dig_d = dig_onehot(idx_q);
    if (lz_mask_s[idx_q]) begin
      seg_d = 8'h00;
    end else begin
      seg_d = {sh_dp_q[idx_q], glyph_s};
    end
    if (in_blank_s) begin
      dig_d = '0;
    end else begin
      dig_d = dig_onehot(idx_q);
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      sh_bcd_q <= 16'h0000;
      sh_dp_q  <= 4'h0;
      frame_q  <= 1'b0;
      seg_q    <= 8'h00;
      dig_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_bcd_q <= sh_bcd_d;
      sh_dp_q  <= sh_dp_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
    end
  end

  // Board polarity is applied only here; everything upstream is active-high.
  assign SEG   = ACT_LOW ? ~seg_q : seg_q;
  assign DIG   = ACT_LOW ? ~dig_q : dig_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed plus randomized bench for seg_scan against a frame/slot arithmetic
// model of the display (SCAN_DIV=4, BLANK_CYC=1, active-low outputs).
module tb_seg_scan;

  localparam int SD = 4;
  localparam int BC = 1;

  logic        CLK_50 = 1'b0;
  logic        reset_n;
  logic [15:0] BCD;
  logic [3:0]  DP;
  logic        LZB;
  logic [7:0]  SEG;
  logic [3:0]  DIG;
  logic        FRAME;

  int          vectors     = 0;
  int          miscompares = 0;
  int          n           = 0;
  logic [15:0] m_sh        = 16'h0000;
  logic [3:0]  m_dp        = 4'h0;
  logic [6:0]  glyph_tbl [16];

  seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACT_LOW(1'b1)) dut (
    .CLK_50  (CLK_50),
    .reset_n (reset_n),
    .BCD     (BCD),
    .DP      (DP),
    .LZB     (LZB),
    .SEG     (SEG),
    .DIG     (DIG),
    .FRAME   (FRAME)
  );

  always #5 CLK_50 = ~CLK_50;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  // One clock: predict what the display should show, then compare #1 after the edge.
  task automatic step();
    int         st, slot, dg;
    logic [3:0] d;
    logic [7:0] es;
    logic [3:0] ed;
    logic       ef;
    @(posedge CLK_50);
    n++;
    st   = n - 1;
    slot = st % SD;
    dg   = (st / SD) % 4;
    d    = m_sh[dg*4 +: 4];
    es   = {m_dp[dg], glyph_tbl[d]};
    if (LZB && dg > 0 && (m_sh >> (4*dg)) == 16'h0000) es = 8'h00;
    es = ~es;
    ed = (slot < BC) ? 4'hF : ~(4'b0001 << dg);
    ef = (n % (4*SD) == 0);
    if (ef) begin
      m_sh = BCD;
      m_dp = DP;
    end
    #1;
    chk("seg", SEG, es);
    chk("dig", {4'h0, DIG}, {4'h0, ed});
    chk("frame", {7'd0, FRAME}, {7'd0, ef});
    chk("dig_onehot", {7'd0, ($countones(~DIG) <= 1)}, 8'd1);
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic chk_at(input int target, input string tag, input logic [7:0] es, input logic [3:0] ed);
    run_to(target);
    chk({tag, "_seg"}, SEG, es);
    chk({tag, "_dig"}, {4'h0, DIG}, {4'h0, ed});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_seg"}, SEG, 8'hFF);
    chk({tag, "_dig"}, {4'h0, DIG}, 8'h0F);
    chk({tag, "_frame"}, {7'd0, FRAME}, 8'd0);
  endtask

  initial begin
    glyph_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    reset_n = 1'b0;
    BCD     = 16'h1234;
    DP      = 4'h0;
    LZB     = 1'b1;
    repeat (3) @(posedge CLK_50);
    #1;
    chk_reset("in_reset");
    @(negedge CLK_50);
    reset_n = 1'b1;
    n = 0;

    // Power-up frame shows shadow zero, then 1234 appears after the first FRAME.
    chk_at(2,  "pre_d0", 8'hC0, 4'hE);
    chk_at(6,  "pre_d1", 8'hFF, 4'hD);
    chk_at(18, "first_d0", 8'h99, 4'hE);
    chk_at(20, "d0_late", 8'h99, 4'hE);
    BCD = 16'h5678;
    chk_at(22, "mid_d1", 8'hB0, 4'hD);
    chk_at(26, "mid_d2", 8'hA4, 4'hB);
    chk_at(30, "mid_d3", 8'hF9, 4'h7);
    chk_at(34, "new_d0", 8'h80, 4'hE);

    // Leading-zero suppression, then LZB dropped live without a new frame.
    BCD = 16'h0090;
    chk_at(50, "lz_d0", 8'hC0, 4'hE);
    chk_at(54, "lz_d1", 8'h90, 4'hD);
    chk_at(58, "lz_d2", 8'hFF, 4'hB);
    chk_at(62, "lz_d3", 8'hFF, 4'h7);
    LZB = 1'b0;
    chk_at(74, "nolz_d2", 8'hC0, 4'hB);
    chk_at(78, "nolz_d3", 8'hC0, 4'h7);

    // Invalid BCD dash and decimal point.
    BCD = 16'h00A0;
    DP  = 4'b0001;
    chk_at(82, "dp_d0", 8'h40, 4'hE);
    chk_at(86, "dash_d1", 8'hBF, 4'hD);

    // Reset mid-slot on digit 2 takes effect at once and clears the shadow.
    run_to(90);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("async_rst");
    @(posedge CLK_50);
    #1;
    chk_reset("held_rst");
    @(negedge CLK_50);
    reset_n = 1'b1;
    n    = 0;
    m_sh = 16'h0000;
    m_dp = 4'h0;
    chk_at(2, "post_rst_d0", 8'hC0, 4'hE);
    chk_at(6, "post_rst_d1", 8'hC0, 4'hD);

    // Random inputs changed at arbitrary points within frames.
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < 4*SD; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          for (int k = 0; k < 4; k++) begin
            BCD[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          end
          DP = 4'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 7) == 0) LZB = ~LZB;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
